// File: rtl/rom_sample_sequencer.sv
// Purpose : address generator + capture stage playing a DEPTH-word sample ROM
//           at a programmable rate, single-shot or looping.
// Latency : 2 cycles from address issue to sample_valid (ROM register + capture).
// Backpressure: none; downstream must accept every sample_valid strobe.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start, stop     start playback from address 0 (when idle) / abort playback
//   loop_en         wrap to address 0 after DEPTH-1 (captured at start)
//   rate_div        issue period minus one, in clk cycles (captured at start)
//   dir             registered ROM address
//   rom_data        ROM output, valid one cycle after dir is registered by the ROM
//   sample_out      last captured sample, held between strobes
//   sample_valid    one-cycle pulse per new sample_out
//   busy            high from start acceptance until done/stop
//   done            one-cycle pulse at the end of single-shot playback
//   checksum        (only with SEQ_CHECKSUM_EN) 16-bit running sum of emitted
//                   samples, cleared on start acceptance
//
// Build option: define SEQ_CHECKSUM_EN to add the checksum output.

module rom_sample_sequencer #(
   parameter int M     = 12,
   parameter int DEPTH = 150,
   parameter int AW    = 10,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             loop_en,
   input  logic [DIV_W-1:0] rate_div,
   output logic [AW-1:0]    dir,
   input  logic [M-1:0]     rom_data,
   output logic [M-1:0]     sample_out,
   output logic             sample_valid,
   output logic             busy,
   output logic             done
`ifdef SEQ_CHECKSUM_EN
   ,
   output logic [15:0]      checksum
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t           state_q, state_d;
   logic [AW-1:0]    dir_q, dir_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] rate_q, rate_d;
   logic             loop_q, loop_d;
   // Read pipeline valid flags:
   //   iss_q : address was issued on the last edge (ROM samples dir next edge)
   //   rd_q  : ROM output register now holds that word (capture next edge)
   //   vld_q : sample_out holds a fresh word this cycle
   logic             iss_q, iss_d;
   logic             rd_q, rd_d;
   logic             vld_q, vld_d;
   logic [M-1:0]     out_q, out_d;
   logic             done_q, done_d;
   logic [AW-1:0]    nxt_addr;

`ifdef SEQ_CHECKSUM_EN
   logic [15:0]      cks_q, cks_d;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         dir_q   <= '0;
         div_q   <= '0;
         rate_q  <= '0;
         loop_q  <= 1'b0;
         iss_q   <= 1'b0;
         rd_q    <= 1'b0;
         vld_q   <= 1'b0;
         out_q   <= '0;
         done_q  <= 1'b0;
`ifdef SEQ_CHECKSUM_EN
         cks_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         div_q   <= div_d;
         rate_q  <= rate_d;
         loop_q  <= loop_d;
         iss_q   <= iss_d;
         rd_q    <= rd_d;
         vld_q   <= vld_d;
         out_q   <= out_d;
         done_q  <= done_d;
`ifdef SEQ_CHECKSUM_EN
         cks_q   <= cks_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      div_d    = div_q;
      rate_d   = rate_q;
      loop_d   = loop_q;
      done_d   = 1'b0;
      // The pipeline advances every cycle; only the issue flag is set by the FSM.
      iss_d    = 1'b0;
      rd_d     = iss_q;
      vld_d    = rd_q;
      out_d    = rd_q ? rom_data : out_q;
      nxt_addr = (dir_q == LAST_ADDR) ? '0 : dir_q + 1'b1;
`ifdef SEQ_CHECKSUM_EN
      cks_d    = vld_q ? cks_q + 16'(out_q) : cks_q;
`endif

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               // The accepting edge is itself the first issue (address 0).
               dir_d  = '0;
               div_d  = '0;
               rate_d = rate_div;
               loop_d = loop_en;
               iss_d  = 1'b1;
               // A one-word table without looping is finished as soon as it issues.
               state_d = (LAST_ADDR == '0 && !loop_en) ? DRAIN : RUN;
`ifdef SEQ_CHECKSUM_EN
               cks_d  = '0;
`endif
            end
         end

         RUN: begin
            if (div_q == rate_q) begin
               div_d = '0;
               dir_d = nxt_addr;
               iss_d = 1'b1;
               // Issuing the final address of a single-shot pass ends issuing;
               // dir then holds at DEPTH-1.
               if (!loop_q && nxt_addr == LAST_ADDR) begin
                  state_d = DRAIN;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         DRAIN: begin
            // Last sample is on the output this cycle and nothing is behind it.
            if (vld_q && !iss_q && !rd_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort overrides everything: flush in-flight reads so no strobe follows
      // the stop edge, and keep the last sample on the output.
      if (stop && state_q != IDLE) begin
         state_d = IDLE;
         done_d  = 1'b0;
         iss_d   = 1'b0;
         rd_d    = 1'b0;
         vld_d   = 1'b0;
         out_d   = out_q;
      end
   end

   assign dir          = dir_q;
   assign sample_out   = out_q;
   assign sample_valid = vld_q;
   assign busy         = (state_q != IDLE);
   assign done         = done_q;
`ifdef SEQ_CHECKSUM_EN
   assign checksum     = cks_q;
`endif

endmodule

// File: tb/tb_rom_sample_sequencer.sv
module tb_rom_sample_sequencer;
   localparam int M     = 12;
   localparam int DEPTH = 150;
   localparam int AW    = 10;
   localparam int DIV_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             stop;
   logic             loop_en;
   logic [DIV_W-1:0] rate_div;
   logic [AW-1:0]    dir;
   logic [M-1:0]     rom_data;
   logic [M-1:0]     sample_out;
   logic             sample_valid;
   logic             busy;
   logic             done;
`ifdef SEQ_CHECKSUM_EN
   logic [15:0]      checksum;
`endif

   int checks = 0;
   int errors = 0;

   logic [M-1:0] rom_mem [DEPTH];
   logic [M-1:0] exp_hold;   // value sample_out is expected to hold

   always #5 clk = ~clk;

   // Registered-output ROM, one cycle read latency.
   always @(posedge clk) begin
      if (int'(dir) < DEPTH) rom_data <= rom_mem[int'(dir)];
      else                   rom_data <= 'x;
   end

   rom_sample_sequencer #(.M(M), .DEPTH(DEPTH), .AW(AW), .DIV_W(DIV_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .loop_en      (loop_en),
      .rate_div     (rate_div),
      .dir          (dir),
      .rom_data     (rom_data),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .busy         (busy),
      .done         (done)
`ifdef SEQ_CHECKSUM_EN
      ,
      .checksum     (checksum)
`endif
   );

   task automatic fill_rom(input bit identity);
      for (int k = 0; k < DEPTH; k++)
         rom_mem[k] = identity ? M'(k) : M'($urandom_range(0, (1 << M) - 1));
   endtask

   // Pulse start so that it is accepted at the next rising edge (E0); returns
   // just after E0 with rate_div/loop_en scrambled, which must have no effect.
   task automatic start_play(input int r, input bit lp);
      @(negedge clk);
      rate_div = DIV_W'(r);
      loop_en  = lp;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      rate_div = DIV_W'($urandom_range(0, 7));
      loop_en  = 1'(($urandom_range(0, 1)));
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; rate_div = '0;
      exp_hold = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++; if (dir !== '0) begin errors++; $display("FAIL reset.dir got %0d exp 0", dir); end
         checks++; if (sample_out !== '0) begin errors++; $display("FAIL reset.sample_out got %0d exp 0", sample_out); end
         checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset.sample_valid got %0b exp 0", sample_valid); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset.busy got %0b exp 0", busy); end
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset.done got %0b exp 0", done); end
`ifdef SEQ_CHECKSUM_EN
         checks++; if (checksum !== 16'd0) begin errors++; $display("FAIL reset.checksum got %0d exp 0", checksum); end
`endif
         reset = 1'b0;   // second pass checks the values survive reset release
         @(negedge clk);
      end
   endtask

   task automatic test_start_stop_idle;
      @(negedge clk);
      start = 1'b1; stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_start_stop.busy c=%0d got %0b exp 0", c, busy); end
         checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL idle_start_stop.valid c=%0d got %0b exp 0", c, sample_valid); end
         checks++; if (dir !== '0) begin errors++; $display("FAIL idle_start_stop.dir c=%0d got %0d exp 0", c, dir); end
      end
   endtask

   // Single-shot pass: issue n at edge n*P, sample n valid in the cycle after
   // edge n*P+2, done one cycle after the last sample.
   task automatic test_single_shot(input int r);
      int p, last, n, sum;
      logic [AW-1:0] ex_dir;
      logic ex_vld, ex_busy, ex_done;
      p = r + 1;
      last = (DEPTH - 1) * p;
      sum = 0;
      for (int k = 0; k < DEPTH; k++) sum += int'(rom_mem[k]);
      start_play(r, 1'b0);
      for (int c = 0; c <= last + 6; c++) begin
         @(negedge clk);
         ex_dir  = AW'((c / p < DEPTH) ? c / p : DEPTH - 1);
         ex_vld  = (c >= 2) && ((c - 2) % p == 0) && ((c - 2) / p < DEPTH);
         ex_busy = (c < last + 3);
         ex_done = (c == last + 3);
         if (c >= 2) begin
            n = (c - 2) / p;
            if (n > DEPTH - 1) n = DEPTH - 1;
            exp_hold = rom_mem[n];
         end
         checks++; if (dir !== ex_dir) begin errors++; $display("FAIL single(r=%0d).dir c=%0d got %0d exp %0d", r, c, dir, ex_dir); end
         checks++; if (sample_valid !== ex_vld) begin errors++; $display("FAIL single(r=%0d).valid c=%0d got %0b exp %0b", r, c, sample_valid, ex_vld); end
         checks++; if (sample_out !== exp_hold) begin errors++; $display("FAIL single(r=%0d).sample_out c=%0d got %0d exp %0d", r, c, sample_out, exp_hold); end
         checks++; if (busy !== ex_busy) begin errors++; $display("FAIL single(r=%0d).busy c=%0d got %0b exp %0b", r, c, busy, ex_busy); end
         checks++; if (done !== ex_done) begin errors++; $display("FAIL single(r=%0d).done c=%0d got %0b exp %0b", r, c, done, ex_done); end
      end
`ifdef SEQ_CHECKSUM_EN
      checks++;
      if (checksum !== 16'(sum)) begin errors++; $display("FAIL single(r=%0d).checksum got %0d exp %0d", r, checksum, 16'(sum)); end
`endif
   endtask

   task automatic test_loop;
      logic [AW-1:0] ex_dir;
      start_play(0, 1'b1);
      for (int c = 0; c <= 201; c++) begin
         @(negedge clk);
         ex_dir = AW'(c % DEPTH);
         if (c >= 2) exp_hold = rom_mem[(c - 2) % DEPTH];
         checks++; if (dir !== ex_dir) begin errors++; $display("FAIL loop.dir c=%0d got %0d exp %0d", c, dir, ex_dir); end
         checks++; if (sample_valid !== (c >= 2)) begin errors++; $display("FAIL loop.valid c=%0d got %0b exp %0b", c, sample_valid, c >= 2); end
         checks++; if (sample_out !== exp_hold) begin errors++; $display("FAIL loop.sample_out c=%0d got %0d exp %0d", c, sample_out, exp_hold); end
         checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL loop.busy_done c=%0d got %0b/%0b exp 1/0", c, busy, done); end
      end
      stop = 1'b1;   // 200 samples emitted; abort on the next edge
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         stop = 1'b0;
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_stop.busy c=%0d got %0b exp 0", c, busy); end
         checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL loop_stop.valid c=%0d got %0b exp 0", c, sample_valid); end
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL loop_stop.done c=%0d got %0b exp 0", c, done); end
         checks++; if (sample_out !== exp_hold) begin errors++; $display("FAIL loop_stop.sample_out c=%0d got %0d exp %0d", c, sample_out, exp_hold); end
      end
   endtask

   task automatic test_stop;
      start_play(0, 1'b0);
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         if (c >= 2) exp_hold = rom_mem[c - 2];
         checks++; if (dir !== AW'(c)) begin errors++; $display("FAIL stop.dir c=%0d got %0d exp %0d", c, dir, c); end
         checks++; if (sample_out !== exp_hold) begin errors++; $display("FAIL stop.sample_out c=%0d got %0d exp %0d", c, sample_out, exp_hold); end
      end
      stop = 1'b1;   // one cycle after address 10 was issued
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         stop = 1'b0;
         checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL stop.valid c=%0d got %0b exp 0", c, sample_valid); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop.busy c=%0d got %0b exp 0", c, busy); end
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop.done c=%0d got %0b exp 0", c, done); end
         checks++; if (sample_out !== rom_mem[8]) begin errors++; $display("FAIL stop.sample_out c=%0d got %0d exp %0d", c, sample_out, rom_mem[8]); end
      end
      exp_hold = rom_mem[8];
   endtask

   task automatic test_start_busy_reset;
      logic ex_vld;
      start_play(0, 1'b0);
      for (int c = 0; c <= 75; c++) begin
         @(negedge clk);
         start = (c == 50);   // restart attempt while busy, must be ignored
         ex_vld = (c >= 2);
         if (c >= 2) exp_hold = rom_mem[c - 2];
         checks++; if (dir !== AW'(c)) begin errors++; $display("FAIL busy_start.dir c=%0d got %0d exp %0d", c, dir, c); end
         checks++; if (sample_valid !== ex_vld) begin errors++; $display("FAIL busy_start.valid c=%0d got %0b exp %0b", c, sample_valid, ex_vld); end
         checks++; if (sample_out !== exp_hold) begin errors++; $display("FAIL busy_start.sample_out c=%0d got %0d exp %0d", c, sample_out, exp_hold); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_start.busy c=%0d got %0b exp 1", c, busy); end
      end
      start = 1'b0;
      #1 reset = 1'b1;   // mid-cycle, well before the next rising edge
      #1;
      checks++; if (dir !== '0) begin errors++; $display("FAIL async_reset.dir got %0d exp 0", dir); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset.busy got %0b exp 0", busy); end
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL async_reset.valid got %0b exp 0", sample_valid); end
      checks++; if (sample_out !== '0) begin errors++; $display("FAIL async_reset.sample_out got %0d exp 0", sample_out); end
`ifdef SEQ_CHECKSUM_EN
      checks++; if (checksum !== 16'd0) begin errors++; $display("FAIL async_reset.checksum got %0d exp 0", checksum); end
`endif
      @(negedge clk);
      reset = 1'b0;
      exp_hold = '0;
   endtask

   initial begin
      test_reset();
      test_start_stop_idle();
      fill_rom(1'b1);
      test_single_shot(0);
      fill_rom(1'b0);
      test_single_shot(3);
      test_single_shot(int'($urandom_range(1, 5)));
      test_loop();
      fill_rom(1'b0);
      test_stop();
      test_start_busy_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rom_sample_sequencer.md
Name: rom_sample_sequencer

Overview:
- Address generator and sample capture stage that drives the 150-word sample ROM on the TOP_NEXYS board.
- Issues addresses at a programmable rate and absorbs the ROM's one-cycle registered read latency.
- Delivers each word downstream with a one-cycle valid strobe.
- Supports single-shot playback or continuous looping of the table.

Parameters:
- M, 12, sample word width (matches ROM word width)
- DEPTH, 150, number of ROM words played (addresses 0..DEPTH-1)
- AW, 10, ROM address width
- DIV_W, 16, width of the rate divider

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  pulse; begins playback from address 0 when idle
- stop  in  1  level/pulse; aborts playback
- loop_en  in  1  1 = wrap to address 0 after DEPTH-1; sampled at start
- rate_div  in  DIV_W  issue period minus one, in clk cycles; sampled at start
- dir  out  AW  ROM address, registered
- rom_data  in  M  ROM data_out (valid one cycle after dir is sampled by ROM)
- sample_out  out  M  last captured sample, held between strobes
- sample_valid  out  1  one-cycle pulse per new sample_out
- busy  out  1  high from start acceptance until done/stop
- done  out  1  one-cycle pulse at end of single-shot playback

Behaviour:
- Reset values: dir=0, sample_out=0, sample_valid=0, busy=0, done=0, state IDLE, divider=0, pipeline flags cleared.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 at edge E0 → RUN, busy=1, dir<=0, capture rate_div and loop_en.
  - E0 counts as the first issue.
- RUN:
  - Divider counts 0..rate_div; an issue occurs every rate_div+1 cycles (rate_div=0 → every cycle).
  - Each issue increments dir by 1.
  - When dir=DEPTH-1 is issued: loop_en=1 → next issue dir=0; loop_en=0 → DRAIN, dir holds.
- Read pipeline: an issue at edge Ek sets dir=k. The ROM registers data at Ek+1. rom_data is captured at Ek+2, so sample_out=word[k] and sample_valid=1 for the cycle after Ek+2. Fixed latency is 2 cycles, implemented as a 2-stage valid shift register.
- DRAIN: waits for the last in-flight sample_valid, then one cycle later done=1 for one cycle, busy=0, → IDLE.
- stop=1 in RUN or DRAIN:
  - Highest priority: → IDLE next edge, busy=0, no done.
  - In-flight pipeline flags are cleared, so no sample_valid is asserted after the stop edge.
  - sample_out holds its last value.
- start while busy: ignored. start and stop in the same cycle in IDLE: stop wins, stays IDLE.
- rate_div/loop_en changes during playback: no effect until the next start.
- dir never exceeds DEPTH-1; comparison is on AW bits.
- Reset mid-playback: all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: SEQ_CHECKSUM_EN
- Defined:
  - Adds output checksum (16 bits), cleared on start acceptance.
  - Adds each emitted sample (zero-extended) mod 2^16 on every sample_valid cycle.
  - Holds after done or stop; reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Start pulse, rate_div=0, loop_en=0, ROM word[k]=k:
  - dir steps 0..149 on consecutive edges.
  - sample_valid high for 150 consecutive cycles beginning 2 cycles after start edge, values 0..149.
  - done pulses one cycle after the last sample; busy low thereafter.
- rate_div=3, loop_en=0: dir changes every 4 cycles; sample_valid pulses are spaced 4 cycles apart; 150 pulses total; sample_out is stable between pulses.
- loop_en=1, rate_div=0:
  - After dir=149 the next dir is 0; samples continue 148, 149, 0, 1 with no gap.
  - No done pulse.
  - Stop asserted after 200 samples → busy=0 next edge; no further sample_valid.
- Stop asserted 1 cycle after dir=10 issue: samples 9 and 10 are not emitted after the stop edge, no done, and sample_out holds 8.
- start while busy at dir=50 → no effect on sequence. Async reset asserted mid-cycle at dir=75 → dir=0 and busy=0 immediately, without waiting for a clk edge.
- With SEQ_CHECKSUM_EN and word[k]=k: checksum=11175 (0x2BA7) after done.
